// File: rtl/pll_reset_sequencer.sv
// Reset/lock sequencer for the pixel-clock PLL, clocked by the PLL reference clock.
// Holds the PLL in reset, qualifies lock, then releases the downstream system reset.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 38,
    parameter int LOCK_TIMEOUT_CYCLES = 375000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int CNT_W               = 20
) (
    input  logic       i_refclk,
    input  logic       i_rst_n,
    input  logic       i_pll_locked,
    input  logic       i_sw_restart,
    output logic       o_pll_rst,
    output logic       o_sys_rst_n,
    output logic [1:0] o_state,
    output logic [7:0] o_relock_count,
    output logic       o_timeout_err
);

    typedef enum logic [1:0] {
        S_RESET_PLL = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABILIZE = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

    logic             r_lock_meta;
    logic             r_lock_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pll_rst;
    logic             r_sys_rst_n;
    logic [7:0]       r_relock_count;
    logic             r_timeout_err;

    state_t           w_state_next;
    logic             w_cnt_clear;
    logic             w_relock_inc;
    logic             w_timeout_set;

    always_ff @(posedge i_refclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= i_pll_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_relock_inc  = 1'b0;
        w_timeout_set = 1'b0;
        if (i_sw_restart) begin
            // Software restart overrides every other event, including lock loss in RUN.
            w_state_next = S_RESET_PLL;
        end else begin
            case (r_state)
                S_RESET_PLL: begin
                    if (r_cnt == C_RST_LAST)
                        w_state_next = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        w_state_next = S_STABILIZE;
                    end else if (r_cnt == C_TIMEOUT_LAST) begin
                        w_state_next  = S_RESET_PLL;
                        w_timeout_set = 1'b1;
                    end
                end
                S_STABILIZE: begin
                    if (!r_lock_s)
                        w_state_next = S_WAIT_LOCK;
                    else if (r_cnt == C_STABLE_LAST)
                        w_state_next = S_RUN;
                end
                S_RUN: begin
                    if (!r_lock_s) begin
                        w_state_next = S_RESET_PLL;
                        w_relock_inc = 1'b1;
                    end
                end
                default: w_state_next = S_RESET_PLL;
            endcase
        end
        // A restart pulse inside RESET_PLL keeps the state but must restart its count.
        w_cnt_clear = i_sw_restart || (w_state_next != r_state);
    end

    always_ff @(posedge i_refclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_RESET_PLL;
            r_cnt          <= '0;
            r_pll_rst      <= 1'b1;
            r_sys_rst_n    <= 1'b0;
            r_relock_count <= 8'd0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_clear ? '0 : r_cnt + 1'b1;
            r_pll_rst   <= (w_state_next == S_RESET_PLL);
            r_sys_rst_n <= (w_state_next == S_RUN);
            if (w_relock_inc && (r_relock_count != 8'hFF))
                r_relock_count <= r_relock_count + 8'd1;
            if (w_timeout_set)
                r_timeout_err <= 1'b1;
        end
    end

    assign o_pll_rst      = r_pll_rst;
    assign o_sys_rst_n    = r_sys_rst_n;
    assign o_state        = r_state;
    assign o_relock_count = r_relock_count;
    assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters (4/20/8).
// Vectors apply inputs at a falling edge, advance n rising edges, then check outputs.
module tb_pll_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       sw_restart;
    logic       pll_rst;
    logic       sys_rst_n;
    logic [1:0] state;
    logic [7:0] relock_count;
    logic       timeout_err;

    int checks   = 0;
    int failures = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (4),
        .LOCK_TIMEOUT_CYCLES(20),
        .LOCK_STABLE_CYCLES (8),
        .CNT_W              (8)
    ) dut (
        .i_refclk      (clk),
        .i_rst_n       (rst_n),
        .i_pll_locked  (pll_locked),
        .i_sw_restart  (sw_restart),
        .o_pll_rst     (pll_rst),
        .o_sys_rst_n   (sys_rst_n),
        .o_state       (state),
        .o_relock_count(relock_count),
        .o_timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       lock;
        logic       sw;
        int         n;
        logic [1:0] st;
        logic       prst;
        logic       sysn;
        logic [7:0] rel;
        logic       to;
    } vec_t;

    vec_t vecs[32];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic prst,
                           input logic sysn, input logic [7:0] rel, input logic to);
        chk({tag, ".state"}, int'(state), int'(st));
        chk({tag, ".pll_rst"}, int'(pll_rst), int'(prst));
        chk({tag, ".sys_rst_n"}, int'(sys_rst_n), int'(sysn));
        chk({tag, ".relock_count"}, int'(relock_count), int'(rel));
        chk({tag, ".timeout_err"}, int'(timeout_err), int'(to));
        $display("check %s: state=%0d pll_rst=%0b sys_rst_n=%0b relock=%0d timeout=%0b",
                 tag, state, pll_rst, sys_rst_n, relock_count, timeout_err);
    endtask

    task automatic apply(input logic lock, input logic sw, input int n);
        pll_locked = lock;
        sw_restart = sw;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Power-up, timeout and first lock
        vecs[0]  = '{1'b0, 1'b0, 3,  2'd0, 1'b1, 1'b0, 8'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1,  2'd1, 1'b0, 1'b0, 8'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 19, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1,  2'd0, 1'b1, 1'b0, 8'd0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 3,  2'd0, 1'b1, 1'b0, 8'd0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1,  2'd1, 1'b0, 1'b0, 8'd0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 2,  2'd1, 1'b0, 1'b0, 8'd0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1,  2'd2, 1'b0, 1'b0, 8'd0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 7,  2'd2, 1'b0, 1'b0, 8'd0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1,  2'd3, 1'b0, 1'b1, 8'd0, 1'b1};
        // Lock loss in RUN and re-lock
        vecs[10] = '{1'b0, 1'b0, 2,  2'd3, 1'b0, 1'b1, 8'd0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1,  2'd0, 1'b1, 1'b0, 8'd1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 4,  2'd1, 1'b0, 1'b0, 8'd1, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 3,  2'd2, 1'b0, 1'b0, 8'd1, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 8,  2'd3, 1'b0, 1'b1, 8'd1, 1'b1};
        // Lock drop seen at STABILIZE count 5, then full requalification
        vecs[15] = '{1'b0, 1'b0, 3,  2'd0, 1'b1, 1'b0, 8'd2, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 4,  2'd1, 1'b0, 1'b0, 8'd2, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 3,  2'd2, 1'b0, 1'b0, 8'd2, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 3,  2'd2, 1'b0, 1'b0, 8'd2, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 3,  2'd1, 1'b0, 1'b0, 8'd2, 1'b1};
        vecs[20] = '{1'b1, 1'b0, 2,  2'd1, 1'b0, 1'b0, 8'd2, 1'b1};
        vecs[21] = '{1'b1, 1'b0, 1,  2'd2, 1'b0, 1'b0, 8'd2, 1'b1};
        vecs[22] = '{1'b1, 1'b0, 7,  2'd2, 1'b0, 1'b0, 8'd2, 1'b1};
        vecs[23] = '{1'b1, 1'b0, 1,  2'd3, 1'b0, 1'b1, 8'd2, 1'b1};
        // sw_restart coincident with synchronized lock loss in RUN
        vecs[24] = '{1'b0, 1'b0, 2,  2'd3, 1'b0, 1'b1, 8'd2, 1'b1};
        vecs[25] = '{1'b0, 1'b1, 1,  2'd0, 1'b1, 1'b0, 8'd2, 1'b1};
        vecs[26] = '{1'b0, 1'b0, 4,  2'd1, 1'b0, 1'b0, 8'd2, 1'b1};
        // sw_restart inside RESET_PLL restarts its count
        vecs[27] = '{1'b0, 1'b1, 1,  2'd0, 1'b1, 1'b0, 8'd2, 1'b1};
        vecs[28] = '{1'b0, 1'b0, 2,  2'd0, 1'b1, 1'b0, 8'd2, 1'b1};
        vecs[29] = '{1'b0, 1'b1, 1,  2'd0, 1'b1, 1'b0, 8'd2, 1'b1};
        vecs[30] = '{1'b0, 1'b0, 3,  2'd0, 1'b1, 1'b0, 8'd2, 1'b1};
        vecs[31] = '{1'b0, 1'b0, 1,  2'd1, 1'b0, 1'b0, 8'd2, 1'b1};

        rst_n      = 1'b0;
        pll_locked = 1'b0;
        sw_restart = 1'b0;
        #12;
        chk_all("reset", 2'd0, 1'b1, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            apply(vecs[i].lock, vecs[i].sw, vecs[i].n);
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].prst, vecs[i].sysn,
                    vecs[i].rel, vecs[i].to);
        end

        // Relock counter saturation over 300 lock losses
        apply(1'b1, 1'b0, 11);
        chk_all("enter_run", 2'd3, 1'b0, 1'b1, 8'd2, 1'b1);
        for (int k = 1; k <= 300; k++) begin
            int exp_rel;
            exp_rel = (2 + k > 255) ? 255 : 2 + k;
            apply(1'b0, 1'b0, 3);
            chk("sat.state_reset", int'(state), 0);
            chk("sat.relock", int'(relock_count), exp_rel);
            apply(1'b1, 1'b0, 13);
            chk("sat.state_run", int'(state), 3);
        end
        $display("check saturation: relock=%0d", relock_count);

        // Asynchronous reset in the middle of STABILIZE
        apply(1'b0, 1'b0, 3);
        apply(1'b1, 1'b0, 8);
        chk_all("mid_stab", 2'd2, 1'b0, 1'b0, 8'd255, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 2'd0, 1'b1, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 1'b0, 3);
        chk_all("post_rst", 2'd0, 1'b1, 1'b0, 8'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sequences reset and lock for the pixel-clock PLL: holds the PLL in reset after power-up, waits for and qualifies lock, then releases the downstream system reset.
- Re-sequences automatically on lock loss or lock timeout, and on software request.
- Runs entirely in the PLL reference-clock domain (37.5 MHz), because the PLL output is not trusted until lock is qualified.
- Sits between the board reference clock/reset and the PLL wrapper's rst/locked pins.

Parameters:
- PLL_RST_CYCLES, 38: cycles pll_rst is held high per reset attempt (≈1 µs at 37.5 MHz); must be ≥1.
- LOCK_TIMEOUT_CYCLES, 375000: cycles allowed in WAIT_LOCK before re-resetting the PLL (10 ms); must be ≥1.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release; must be ≥1.
- CNT_W, 20: shared counter width; must hold max(all three) − 1.

Ports:
- refclk, input, 1: clock; the same reference clock that feeds the PLL.
- rst_n, input, 1: asynchronous active-low reset.
- pll_locked, input, 1: PLL locked pin; asynchronous to refclk.
- sw_restart, input, 1: single-cycle pulse, synchronous to refclk; forces a full re-sequence.
- pll_rst, output, 1: drives the PLL rst pin; active-high.
- sys_rst_n, output, 1: downstream reset, active-low. Each consumer domain must re-synchronize its deassertion.
- state, output, 2: 0=RESET_PLL, 1=WAIT_LOCK, 2=STABILIZE, 3=RUN.
- relock_count, output, 8: count of lock losses while in RUN; saturates at 255.
- timeout_err, output, 1: sticky; set on any lock timeout.

Behaviour:
- **Synchronizer:** pll_locked passes through a 2-FF synchronizer (lock_s). The FSM only ever sees lock_s. Both flops reset to 0.
- **Reset (rst_n=0, asynchronous):**
  - state=RESET_PLL, counter=0.
  - pll_rst=1, sys_rst_n=0.
  - relock_count=0, timeout_err=0.
- **Registered outputs:** pll_rst and sys_rst_n are registers equal to the decode of the current state every cycle.
  - pll_rst=1 iff state==RESET_PLL.
  - sys_rst_n=1 iff state==RUN.
- **Counter:** cleared to 0 on every state change; otherwise increments by 1 each cycle.
- **RESET_PLL:** when counter==PLL_RST_CYCLES−1, go to WAIT_LOCK. pll_rst is high for exactly PLL_RST_CYCLES cycles.
- **WAIT_LOCK:**
  - lock_s=1 → STABILIZE.
  - Else, if counter==LOCK_TIMEOUT_CYCLES−1 → RESET_PLL and set timeout_err.
- **STABILIZE:**
  - lock_s=0 → WAIT_LOCK, with a fresh timeout window.
  - Else, if counter==LOCK_STABLE_CYCLES−1 → RUN.
- **RUN:** lock_s=0 → RESET_PLL, and relock_count increments unless it is already 255.
- **sw_restart=1 in any state** → RESET_PLL next cycle. It has priority over every other transition and does not touch relock_count or timeout_err. A pulse during RESET_PLL restarts that state's count from 0.
- **Simultaneous events:** in RUN, sw_restart together with lock_s=0 is treated as sw_restart only, so no increment.
- **Latency:**
  - pll_locked rising while in WAIT_LOCK → sys_rst_n=1 after 2 (sync) + 1 + LOCK_STABLE_CYCLES cycles.
  - lock_s falling while in RUN → sys_rst_n=0 and pll_rst=1 on the next edge.
- **Glitches:** a lock glitch shorter than one cycle may be missed by the synchronizer. That is acceptable; no filtering beyond STABILIZE.
- **Reset mid-operation:** asserting rst_n in any state returns everything to the reset values immediately, without waiting for a clock edge.
- **Counter overflow:** impossible when CNT_W is sized per its parameter rule. No wrap is required.

Test Plan (PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8):
1. Release rst_n with pll_locked=0 → pll_rst=1 for exactly 4 cycles, then state=1; after 20 cycles in WAIT_LOCK → state=0 and timeout_err=1; 4 cycles later → state=1 again.
2. pll_locked=1 applied during WAIT_LOCK → state=2 three edges later; sys_rst_n=1 and state=3 after 8 further cycles; relock_count=0.
3. In RUN, drop pll_locked → state=0, pll_rst=1 and sys_rst_n=0 three edges after the drop; relock_count=1; the cycle repeats and reaches RUN again once lock returns.
4. In STABILIZE at counter=5, drop pll_locked for 3 cycles → state returns to 1 with no RUN entry; on relock, a full 8-cycle qualification restarts from 0.
5. Pulse sw_restart in RUN, with pll_locked simultaneously falling → state=0 next cycle; relock_count unchanged; timeout_err unchanged.
6. Force 300 lock losses in RUN → relock_count holds at 255. Assert rst_n low mid-STABILIZE → all outputs return to reset values asynchronously.
